// File: rtl/vrf_pkg.sv
// Shared constants and types for the lane-organised vector register file.
package vrf_pkg;
   localparam int unsigned VRF_LANES  = 4;
   localparam int unsigned VRF_LANE_W = 32;
   localparam int unsigned VRF_DEPTH  = 16;

   typedef logic [VRF_LANE_W-1:0] lane_t;

   typedef enum logic {LDR_IDLE, LDR_FILL} ldr_state_t;
endpackage

// File: rtl/vrf_lane_loader.sv
// Lane-serial loader: gathers one vector a lane per beat and raises commit_en on the final beat.
module vrf_lane_loader
   import vrf_pkg::*;
#(
   parameter int unsigned LANES  = VRF_LANES,
   parameter int unsigned LANE_W = VRF_LANE_W,
   parameter int unsigned AW     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ls_start,
   input  logic [AW-1:0]           ls_addr,
   input  logic                    ls_valid,
   input  logic [LANE_W-1:0]       ls_data,
   output logic                    ls_ready,
   output logic                    ls_done,
   output logic                    busy,
   output logic                    commit_en,
   output logic [AW-1:0]           commit_addr,
   output logic [LANES*LANE_W-1:0] commit_data
);
   localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned VW = LANES * LANE_W;

   ldr_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] stage_q, stage_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LDR_IDLE;
         cnt_q   <= '0;
         stage_q <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   // Final lane bypasses staging so the commit lands on the same edge as the last beat.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      addr_d      = addr_q;
      done_d      = 1'b0;
      commit_en   = 1'b0;
      commit_data = stage_q;
      commit_data[(LANES-1)*LANE_W +: LANE_W] = ls_data;
      unique case (state_q)
         LDR_IDLE: begin
            if (ls_start) begin
               state_d = LDR_FILL;
               cnt_d   = '0;
               addr_d  = ls_addr;
            end
         end
         LDR_FILL: begin
            if (ls_valid) begin
               for (int unsigned i = 0; i < LANES; i++) begin
                  if (cnt_q == CW'(i)) stage_d[i*LANE_W +: LANE_W] = ls_data;
               end
               if (cnt_q == CW'(LANES-1)) begin
                  commit_en = 1'b1;
                  state_d   = LDR_IDLE;
                  cnt_d     = '0;
                  done_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = LDR_IDLE;
      endcase
   end

   assign commit_addr = addr_q;
   assign busy        = (state_q == LDR_FILL);
   assign ls_ready    = (state_q == LDR_FILL);
   assign ls_done     = done_q;
endmodule

// File: rtl/vector_register_file_lanes.sv
// Vector register file: two combinational reads, masked full-vector write, lane-serial load port.
// Optional same-cycle write-to-read bypass when VRF_WRITE_BYPASS_EN is defined.
module vector_register_file_lanes
   import vrf_pkg::*;
#(
   parameter  int unsigned LANES  = VRF_LANES,
   parameter  int unsigned LANE_W = VRF_LANE_W,
   parameter  int unsigned DEPTH  = VRF_DEPTH,
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we3,
   input  logic [LANES-1:0]        wmask3,
   input  logic [AW-1:0]           wa3,
   input  logic [LANES*LANE_W-1:0] wd3,
   input  logic [AW-1:0]           ra1,
   input  logic [AW-1:0]           ra2,
   output logic [LANES*LANE_W-1:0] rd1,
   output logic [LANES*LANE_W-1:0] rd2,
   input  logic                    ls_start,
   input  logic [AW-1:0]           ls_addr,
   input  logic                    ls_valid,
   input  logic [LANE_W-1:0]       ls_data,
   output logic                    ls_ready,
   output logic                    ls_done,
   output logic                    busy
);
   localparam int unsigned VW = LANES * LANE_W;

   logic [VW-1:0] mem [DEPTH];
   logic          commit_en;
   logic [AW-1:0] commit_addr;
   logic [VW-1:0] commit_data;

   vrf_lane_loader #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .AW     (AW)
   ) u_loader (
      .clk         (clk),
      .rst         (rst),
      .ls_start    (ls_start),
      .ls_addr     (ls_addr),
      .ls_valid    (ls_valid),
      .ls_data     (ls_data),
      .ls_ready    (ls_ready),
      .ls_done     (ls_done),
      .busy        (busy),
      .commit_en   (commit_en),
      .commit_addr (commit_addr),
      .commit_data (commit_data)
   );

   // Port 3 is written after the commit so its masked lanes win on an address clash.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < DEPTH; r++) mem[r] <= '0;
      end else begin
         if (commit_en) mem[commit_addr] <= commit_data;
         if (we3) begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (wmask3[i]) mem[wa3][i*LANE_W +: LANE_W] <= wd3[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   function automatic logic [VW-1:0] read_port(input logic [AW-1:0] ra);
      logic [VW-1:0] v;
      v = mem[ra];
`ifdef VRF_WRITE_BYPASS_EN
      if (commit_en && (commit_addr == ra)) v = commit_data;
      if (we3 && (wa3 == ra)) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (wmask3[i]) v[i*LANE_W +: LANE_W] = wd3[i*LANE_W +: LANE_W];
         end
      end
`endif
      return v;
   endfunction

   always_comb rd1 = read_port(ra1);
   always_comb rd2 = read_port(ra2);
endmodule

// File: tb/tb_vector_register_file_lanes.sv
// Self-checking bench: directed scenarios then random traffic against a lane-array/queue model.
module tb_vector_register_file_lanes;
   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 32;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned AW     = 4;
   localparam int unsigned VW     = LANES * LANE_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              we3;
   logic [LANES-1:0]  wmask3;
   logic [AW-1:0]     wa3, ra1, ra2, ls_addr;
   logic [VW-1:0]     wd3, rd1, rd2;
   logic              ls_start, ls_valid, ls_ready, ls_done, busy;
   logic [LANE_W-1:0] ls_data;

   always #5 clk = ~clk;

   vector_register_file_lanes dut (
      .clk(clk), .rst(rst), .we3(we3), .wmask3(wmask3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .ls_start(ls_start), .ls_addr(ls_addr), .ls_valid(ls_valid), .ls_data(ls_data),
      .ls_ready(ls_ready), .ls_done(ls_done), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: registers as lane arrays, load as a queue of accepted beats.
   logic [LANE_W-1:0] m [DEPTH][LANES];
   bit                ld_busy;
   bit                ld_done;
   logic [AW-1:0]     ld_dest;
   logic [LANE_W-1:0] ld_q [$];

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] expect_rd(input logic [AW-1:0] a);
      logic [VW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = m[a][i];
`ifdef VRF_WRITE_BYPASS_EN
      if (ld_busy && ls_valid && (ld_q.size() == LANES-1) && (ld_dest == a)) begin
         for (int i = 0; i < LANES-1; i++) v[i*LANE_W +: LANE_W] = ld_q[i];
         v[(LANES-1)*LANE_W +: LANE_W] = ls_data;
      end
      if (we3 && (wa3 == a)) begin
         for (int i = 0; i < LANES; i++)
            if (wmask3[i]) v[i*LANE_W +: LANE_W] = wd3[i*LANE_W +: LANE_W];
      end
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < DEPTH; r++)
         for (int i = 0; i < LANES; i++) m[r][i] = '0;
      ld_busy = 1'b0;
      ld_done = 1'b0;
      ld_dest = '0;
      ld_q.delete();
   endtask

   task automatic model_edge();
      ld_done = 1'b0;
      if (ld_busy) begin
         if (ls_valid) begin
            ld_q.push_back(ls_data);
            if (ld_q.size() == LANES) begin
               for (int i = 0; i < LANES; i++) m[ld_dest][i] = ld_q[i];
               ld_q.delete();
               ld_busy = 1'b0;
               ld_done = 1'b1;
            end
         end
      end else if (ls_start) begin
         ld_busy = 1'b1;
         ld_dest = ls_addr;
         ld_q.delete();
      end
      if (we3) begin
         for (int i = 0; i < LANES; i++)
            if (wmask3[i]) m[wa3][i] = wd3[i*LANE_W +: LANE_W];
      end
   endtask

   task automatic idle();
      we3 = 1'b0; wmask3 = '0; wa3 = '0; wd3 = '0;
      ls_start = 1'b0; ls_addr = '0; ls_valid = 1'b0; ls_data = '0;
   endtask

   // Check outputs mid-cycle, then advance one edge and update the model.
   task automatic step();
      @(negedge clk);
      check_eq("rd1", rd1, expect_rd(ra1));
      check_eq("rd2", rd2, expect_rd(ra2));
      check_eq("busy", VW'(busy), VW'(ld_busy));
      check_eq("ls_ready", VW'(ls_ready), VW'(ld_busy));
      check_eq("ls_done", VW'(ls_done), VW'(ld_done));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic beat(input logic [LANE_W-1:0] d);
      ls_valid = 1'b1; ls_data = d;
      step();
      ls_valid = 1'b0;
   endtask

   int done_pulses;

   initial begin
      rst = 1'b1;
      idle();
      ra1 = '0; ra2 = '0;
      model_reset();
      step();
      step();
      rst = 1'b0;

      // Full-vector write then read back
      we3 = 1'b1; wmask3 = 4'b1111; wa3 = 4'd0;
      wd3 = {32'd4, 32'd3, 32'd2, 32'd1};
      step();
      idle();
      step();
      check_eq("t1_reg0", rd1, {32'd4, 32'd3, 32'd2, 32'd1});

      // Masked write
      we3 = 1'b1; wmask3 = 4'b0101; wa3 = 4'd0; wd3 = {4{32'hAAAA_AAAA}};
      step();
      idle();
      step();
      check_eq("t2_reg0", rd1, {32'd4, 32'hAAAA_AAAA, 32'd2, 32'hAAAA_AAAA});

      // Serial load into reg 5 with a two-cycle gap after the first beat
      ra1 = 4'd5; ra2 = 4'd5;
      ls_start = 1'b1; ls_addr = 4'd5;
      step();
      ls_start = 1'b0;
      beat(32'd10);
      step();
      step();
      beat(32'd20);
      beat(32'd30);
      check_eq("t3_old", rd1, '0);
      beat(32'd40);
      check_eq("t3_new", rd1, {32'd40, 32'd30, 32'd20, 32'd10});
      check_eq("t3_done", VW'(ls_done), VW'(1));
      step();
      check_eq("t3_done_once", VW'(ls_done), VW'(0));

      // Reset mid-load
      we3 = 1'b1; wmask3 = 4'b1111; wa3 = 4'd5; wd3 = {4{32'd1}};
      step();
      idle();
      ls_start = 1'b1; ls_addr = 4'd5;
      step();
      ls_start = 1'b0;
      beat(32'd77);
      beat(32'd78);
      rst = 1'b1;
      #1;
      check_eq("t4_busy", VW'(busy), VW'(0));
      check_eq("t4_ready", VW'(ls_ready), VW'(0));
      check_eq("t4_reg5", rd1, '0);
      model_reset();
      step();
      rst = 1'b0;
      step();
      check_eq("t4_no_done", VW'(ls_done), VW'(0));

      // Final beat collides with masked we3 to the same register; late ls_start ignored
      ra1 = 4'd3;
      ls_start = 1'b1; ls_addr = 4'd3;
      step();
      ls_start = 1'b0;
      beat(32'd9);
      beat(32'd9);
      beat(32'd9);
      we3 = 1'b1; wmask3 = 4'b0001; wa3 = 4'd3; wd3 = {96'd0, 32'd7};
      ls_start = 1'b1; ls_addr = 4'd7;
      beat(32'd9);
      idle();
      check_eq("t5_reg3", rd1, {32'd9, 32'd9, 32'd9, 32'd7});
      check_eq("t5_idle", VW'(busy), VW'(0));
      step();

      // Write and read of the same register in one cycle
      ra2 = 4'd2;
      we3 = 1'b1; wmask3 = 4'b1111; wa3 = 4'd2; wd3 = {4{32'h55}};
      step();
      idle();
      step();
      check_eq("t6_next", rd2, {4{32'h55}});

      // Random traffic
      done_pulses = 0;
      for (int c = 0; c < 600; c++) begin
         we3      = ($urandom_range(0, 2) == 0);
         wmask3   = LANES'($urandom);
         wa3      = AW'($urandom);
         wd3      = {$urandom, $urandom, $urandom, $urandom};
         ls_start = ($urandom_range(0, 5) == 0);
         ls_addr  = AW'($urandom);
         ls_valid = ($urandom_range(0, 9) < 6);
         ls_data  = $urandom;
         ra1      = ($urandom_range(0, 1) == 0) ? ls_addr : AW'($urandom);
         ra2      = ($urandom_range(0, 1) == 0) ? wa3 : AW'($urandom);
         if (ld_done) done_pulses++;
         step();
      end
      idle();
      step();
      check_eq("rand_loads_seen", VW'(done_pulses > 0), VW'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
